// File: rtl/risc_v_pipeline_pkg.sv
// Shared pipeline-control definitions used by hazard_ctrl and its sub-blocks.
//   hz_state_t   : hazard FSM state encoding
//   pipe_ctrl_t  : bundle of pipeline-register enables, flushes and pc select
//   CTRL_*       : canned control patterns for each kind of cycle
//   load_use_hazard() : load-use detection between EX and ID
package risc_v_pipeline_pkg;

   localparam int MEM_TIMEOUT_DEF  = 16;
   localparam int DRAIN_CYCLES_DEF = 3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_ERR      = 2'd3
   } hz_state_t;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic id_ex_we;
      logic ex_mem_we;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_flush;
      logic pc_sel;
   } pipe_ctrl_t;

   // Free-running pipeline.
   localparam pipe_ctrl_t CTRL_RUN      = pipe_ctrl_t'(8'b1111_0000);
   // Hold PC and IF/ID, push a bubble into EX.
   localparam pipe_ctrl_t CTRL_LOAD_USE = pipe_ctrl_t'(8'b0011_0100);
   // Redirect PC to the EX target and squash the two younger instructions.
   localparam pipe_ctrl_t CTRL_BRANCH   = pipe_ctrl_t'(8'b1111_1101);
   // Fence waiting for the back end to empty: same shape as a load-use bubble.
   localparam pipe_ctrl_t CTRL_DRAIN    = pipe_ctrl_t'(8'b0011_0100);
   // Data memory not ready: freeze everything up to MEM, bubble into WB.
   localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(8'b0000_0010);
   // Reset and error: nothing advances, every stage is squashed.
   localparam pipe_ctrl_t CTRL_HALT     = pipe_ctrl_t'(8'b0000_1110);

   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       use_rs1,
      input logic       use_rs2
   );
      logic hit1;
      logic hit2;
      hit1 = use_rs1 && (rs1 == ex_rd);
      hit2 = use_rs2 && (rs2 == ex_rd);
      // x0 is hardwired to zero, a load into it never produces a value to wait for.
      return ex_mem_read && (ex_rd != 5'd0) && (hit1 || hit2);
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   clear_i : synchronous clear, has priority over inc_i
//   inc_i   : add one this cycle unless already at all-ones
//   count_o : current count
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != '1)) begin
         count_o <= count_o + WIDTH'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Handles load-use bubbles, taken-branch redirects, data-memory wait states
// with timeout, and fence draining; keeps a saturating count of stall cycles.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   id_*                       : source registers / use flags / fence of ID instr
//   ex_rd_i, ex_mem_read_i     : destination and load flag of EX instr
//   ex_branch_taken_i          : EX resolved a taken branch or jump
//   mem_req_i, dmem_ready_i    : MEM stage access handshake
//   *_we_o, *_flush_o          : pipeline-register enables and bubble inserts
//   pc_sel_o                   : PC takes the EX branch target
//   err_o                      : sticky memory timeout
//   stall_cnt_o                : saturating count of cycles with pc_we_o low
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; branch / load-use / fence decoded each cycle
// MEM_WAIT | data memory busy, pipeline frozen, timeout counting
// DRAIN    | fence held in ID while EX/MEM/WB empty, then fence issues
// ERR      | memory timeout, pipeline halted until reset
module hazard_ctrl
   import risc_v_pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_use_rs1_i,
   input  logic        id_use_rs2_i,
   input  logic        id_fence_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_mem_read_i,
   input  logic        ex_branch_taken_i,
   input  logic        mem_req_i,
   input  logic        dmem_ready_i,
   output logic        pc_we_o,
   output logic        if_id_we_o,
   output logic        id_ex_we_o,
   output logic        ex_mem_we_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        mem_wb_flush_o,
   output logic        pc_sel_o,
   output logic        err_o,
   output logic [15:0] stall_cnt_o
);

   localparam int WAIT_W  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   // The cycle that first sees the stall/fence is spent in RUN and already
   // counts toward the budget, so the in-state counters stop one short.
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 2);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   hz_state_t          state_q, state_nxt;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_nxt;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_nxt;
   logic               err_q, err_nxt;

   pipe_ctrl_t ctrl;
   pipe_ctrl_t run_ctrl;
   logic       run_fence;
   logic       load_use;
   logic       mem_stall;
   logic       stall_inc;

   assign load_use  = load_use_hazard(ex_mem_read_i, ex_rd_i, id_rs1_i, id_rs2_i,
                                      id_use_rs1_i, id_use_rs2_i);
   assign mem_stall = mem_req_i && !dmem_ready_i;

   // Decode of a normal issue cycle; branch beats load-use beats fence.
   always_comb begin
      run_ctrl  = CTRL_RUN;
      run_fence = 1'b0;
      if (ex_branch_taken_i) begin
         run_ctrl = CTRL_BRANCH;
      end else if (load_use) begin
         run_ctrl = CTRL_LOAD_USE;
      end else if (id_fence_i) begin
         run_ctrl  = CTRL_DRAIN;
         run_fence = 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      wait_cnt_nxt  = wait_cnt_q;
      drain_cnt_nxt = drain_cnt_q;
      err_nxt       = err_q;
      ctrl          = CTRL_RUN;

      case (state_q)
         ST_RUN: begin
            if (mem_stall) begin
               ctrl         = CTRL_FREEZE;
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = '0;
            end else begin
               ctrl = run_ctrl;
               if (run_fence) begin
                  state_nxt     = ST_DRAIN;
                  drain_cnt_nxt = '0;
               end
            end
         end

         ST_MEM_WAIT: begin
            if (dmem_ready_i) begin
               // Everything was frozen, so whatever sat in EX/ID is decoded now.
               ctrl      = run_ctrl;
               state_nxt = ST_RUN;
               if (run_fence) begin
                  state_nxt     = ST_DRAIN;
                  drain_cnt_nxt = '0;
               end
            end else begin
               ctrl = CTRL_FREEZE;
               if (wait_cnt_q == WAIT_LAST) begin
                  state_nxt = ST_ERR;
                  err_nxt   = 1'b1;
               end else begin
                  wait_cnt_nxt = wait_cnt_q + WAIT_W'(1);
               end
            end
         end

         ST_DRAIN: begin
            if (mem_stall) begin
               // The fence stays in ID while frozen and re-drains on release.
               ctrl         = CTRL_FREEZE;
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = '0;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               // Back end is empty: let the fence itself advance exactly once.
               ctrl      = run_fence ? CTRL_RUN : run_ctrl;
               state_nxt = ST_RUN;
            end else begin
               ctrl          = CTRL_DRAIN;
               drain_cnt_nxt = drain_cnt_q + DRAIN_W'(1);
            end
         end

         ST_ERR: begin
            ctrl = CTRL_HALT;
         end

         default: begin
            ctrl      = CTRL_HALT;
            state_nxt = ST_RUN;
         end
      endcase

      if (rst_i) begin
         ctrl = CTRL_HALT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         wait_cnt_q  <= wait_cnt_nxt;
         drain_cnt_q <= drain_cnt_nxt;
         err_q       <= err_nxt;
      end
   end

   assign stall_inc = !ctrl.pc_we && !rst_i;

   sat_counter #(
      .WIDTH (16)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .clear_i (rst_i),
      .inc_i   (stall_inc),
      .count_o (stall_cnt_o)
   );

   assign pc_we_o        = ctrl.pc_we;
   assign if_id_we_o     = ctrl.if_id_we;
   assign id_ex_we_o     = ctrl.id_ex_we;
   assign ex_mem_we_o    = ctrl.ex_mem_we;
   assign if_id_flush_o  = ctrl.if_id_flush;
   assign id_ex_flush_o  = ctrl.id_ex_flush;
   assign mem_wb_flush_o = ctrl.mem_wb_flush;
   assign pc_sel_o       = ctrl.pc_sel;
   assign err_o          = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Each cycle the driver sets the inputs and
// pushes the expected control pattern (with a mask of the bits that matter for
// that kind of cycle), err_o and stall_cnt_o; the negedge checker pops and compares.
module tb_hazard_ctrl;

   // bit order: pc_we if_id_we id_ex_we ex_mem_we if_id_flush id_ex_flush mem_wb_flush pc_sel
   localparam logic [7:0] E_RUN = 8'b1111_0000, M_RUN = 8'hFF;
   localparam logic [7:0] E_LU  = 8'b0000_0100, M_LU  = 8'b1100_0101;
   localparam logic [7:0] E_BR  = 8'b1000_1101, M_BR  = 8'b1000_1101;
   localparam logic [7:0] E_FRZ = 8'b0000_0010, M_FRZ = 8'b1111_0011;
   localparam logic [7:0] E_DRN = 8'b0000_0100, M_DRN = 8'b1100_0101;
   localparam logic [7:0] E_ERR = 8'b0000_1110, M_ERR = 8'b1111_1110;
   localparam logic [7:0] E_RST = 8'b0000_1110, M_RST = 8'hFF;

   typedef struct {
      logic [7:0]  e;
      logic [7:0]  m;
      logic        err;
      logic [15:0] stall;
      logic        cnt_chk;
      int          idx;
   } exp_t;

   logic        clk;
   logic        rst_i;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        use1, use2, fence, ex_ld, br, mem_req, ready;
   logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
   logic        if_id_fl, id_ex_fl, mem_wb_fl, pc_sel, err;
   logic [15:0] stall_cnt;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          step_idx = 0;
   logic [15:0] exp_stall = '0;

   hazard_ctrl dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .id_rs1_i          (id_rs1),
      .id_rs2_i          (id_rs2),
      .id_use_rs1_i      (use1),
      .id_use_rs2_i      (use2),
      .id_fence_i        (fence),
      .ex_rd_i           (ex_rd),
      .ex_mem_read_i     (ex_ld),
      .ex_branch_taken_i (br),
      .mem_req_i         (mem_req),
      .dmem_ready_i      (ready),
      .pc_we_o           (pc_we),
      .if_id_we_o        (if_id_we),
      .id_ex_we_o        (id_ex_we),
      .ex_mem_we_o       (ex_mem_we),
      .if_id_flush_o     (if_id_fl),
      .id_ex_flush_o     (id_ex_fl),
      .mem_wb_flush_o    (mem_wb_fl),
      .pc_sel_o          (pc_sel),
      .err_o             (err),
      .stall_cnt_o       (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t r;
         logic [7:0] obs;
         r   = sb.pop_front();
         obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, mem_wb_fl, pc_sel};
         check_eq($sformatf("ctrl@%0d", r.idx), {24'd0, obs & r.m}, {24'd0, r.e & r.m});
         if (r.cnt_chk) begin
            check_eq($sformatf("err@%0d", r.idx), {31'd0, err}, {31'd0, r.err});
            check_eq($sformatf("stall_cnt@%0d", r.idx), {16'd0, stall_cnt}, {16'd0, r.stall});
         end
      end
   end

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      use1 = 1'b0; use2 = 1'b0; fence = 1'b0; ex_ld = 1'b0;
      br = 1'b0; mem_req = 1'b0; ready = 1'b0;
   endtask

   // One clock cycle with the inputs already set by the caller.
   task automatic cyc(input logic r, input logic [7:0] e, input logic [7:0] m, input logic ee);
      exp_t x;
      rst_i     = r;
      x.e       = e;
      x.m       = m;
      x.err     = ee;
      x.stall   = exp_stall;
      x.cnt_chk = !r;
      x.idx     = step_idx;
      sb.push_back(x);
      step_idx++;
      if (r) exp_stall = '0;
      else if (!e[7] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst_i = 1'b1;
      @(posedge clk);
      #1;

      // reset, then idle RUN
      cyc(1, E_RST, M_RST, 0);
      cyc(1, E_RST, M_RST, 0);
      cyc(0, E_RUN, M_RUN, 0);
      cyc(0, E_RUN, M_RUN, 0);

      // load-use on rs1 (x5): one bubble
      ex_ld = 1; ex_rd = 5'd5; id_rs1 = 5'd5; use1 = 1;
      cyc(0, E_LU, M_LU, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);

      // load-use on rs2, then same regs but rs2 not used
      ex_ld = 1; ex_rd = 5'd7; id_rs2 = 5'd7; use2 = 1;
      cyc(0, E_LU, M_LU, 0);
      use2 = 0;
      cyc(0, E_RUN, M_RUN, 0);
      idle();

      // load into x0 never stalls
      ex_ld = 1; ex_rd = 5'd0; id_rs1 = 5'd0; use1 = 1; id_rs2 = 5'd0; use2 = 1;
      cyc(0, E_RUN, M_RUN, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);

      // branch beats load-use, then branch alone
      ex_ld = 1; ex_rd = 5'd5; id_rs1 = 5'd5; use1 = 1; br = 1;
      cyc(0, E_BR, M_BR, 0);
      idle(); br = 1;
      cyc(0, E_BR, M_BR, 0);
      idle();

      // memory wait: 4 frozen cycles, released on the 5th
      mem_req = 1; ready = 0;
      repeat (4) cyc(0, E_FRZ, M_FRZ, 0);
      ready = 1;
      cyc(0, E_RUN, M_RUN, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);

      // branch frozen by a memory wait is applied on release
      mem_req = 1; ready = 0; br = 1;
      cyc(0, E_FRZ, M_FRZ, 0);
      cyc(0, E_FRZ, M_FRZ, 0);
      ready = 1;
      cyc(0, E_BR, M_BR, 0);
      idle();

      // fence: three drain cycles, then the fence issues once
      fence = 1;
      repeat (3) cyc(0, E_DRN, M_DRN, 0);
      cyc(0, E_RUN, M_RUN, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);

      // branch beats fence
      fence = 1; br = 1;
      cyc(0, E_BR, M_BR, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);

      // memory stall during drain, drain restarts afterwards
      fence = 1;
      cyc(0, E_DRN, M_DRN, 0);
      mem_req = 1; ready = 0;
      cyc(0, E_FRZ, M_FRZ, 0);
      cyc(0, E_FRZ, M_FRZ, 0);
      ready = 1;
      repeat (3) cyc(0, E_DRN, M_DRN, 0);
      cyc(0, E_RUN, M_RUN, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);

      // reset during a fence drain
      fence = 1;
      cyc(0, E_DRN, M_DRN, 0);
      cyc(1, E_RST, M_RST, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);
      cyc(0, E_RUN, M_RUN, 0);

      // 15 wait cycles is still within the timeout
      mem_req = 1; ready = 0;
      repeat (15) cyc(0, E_FRZ, M_FRZ, 0);
      ready = 1;
      cyc(0, E_RUN, M_RUN, 0);
      idle();
      cyc(0, E_RUN, M_RUN, 0);

      // 16 wait cycles: timeout, sticky error, cleared by reset
      mem_req = 1; ready = 0;
      repeat (16) cyc(0, E_FRZ, M_FRZ, 0);
      cyc(0, E_ERR, M_ERR, 1);
      ready = 1;
      cyc(0, E_ERR, M_ERR, 1);
      idle();
      cyc(0, E_ERR, M_ERR, 1);
      cyc(1, E_RST, M_RST, 1);
      cyc(0, E_RUN, M_RUN, 0);

      // reset in the middle of a memory wait leaves nothing pending
      mem_req = 1; ready = 0;
      repeat (3) cyc(0, E_FRZ, M_FRZ, 0);
      idle();
      cyc(1, E_RST, M_RST, 0);
      cyc(0, E_RUN, M_RUN, 0);
      ready = 1;
      cyc(0, E_RUN, M_RUN, 0);
      idle();

      @(negedge clk);
      #1;
      check_eq("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
